// File: rtl/delay_arbiter_if.sv
// Handshake bundle between the requesters and delay_arbiter.
// The master side drives requests and response acceptance; the slave side is the arbiter.
interface delay_arbiter_if #(
  parameter int NREQ    = 2,
  parameter int MAX_LAT = 15
);
  localparam int LW = $clog2(MAX_LAT + 1);
  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0] req_valid;
  logic [NREQ-1:0] req_ready;
  logic [LW-1:0]   cfg_lat;
  logic [NREQ-1:0] resp_valid;
  logic [NREQ-1:0] resp_ready;
  logic            busy;
  logic [GW-1:0]   grant_id;

  modport master (
    output req_valid, cfg_lat, resp_ready,
    input  req_ready, resp_valid, busy, grant_id
  );

  modport slave (
    input  req_valid, cfg_lat, resp_ready,
    output req_ready, resp_valid, busy, grant_id
  );
endinterface

// File: rtl/delay_arbiter.sv
// Round-robin arbiter sharing one fixed-latency slot among NREQ requesters;
// one transaction in flight, latency captured from cfg_lat at the request handshake.
module delay_arbiter #(
  parameter int NREQ    = 2,
  parameter int MAX_LAT = 15
) (
  input logic             clk,
  input logic             rst_n,
  delay_arbiter_if.slave  arb
);
  localparam int LW = $clog2(MAX_LAT + 1);
  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [LW-1:0]   cnt_q, cnt_d;
  logic [GW-1:0]   last_q, last_d;
  logic [GW-1:0]   grant_q, grant_d;
  logic [GW-1:0]   sel;
  logic            selFound;
  logic [LW-1:0]   latClamped;
  logic [NREQ-1:0] reqReady;
  logic [NREQ-1:0] respValid;

  // Scan downwards so the candidate closest to last+1 is the one left standing.
  always_comb begin
    sel      = '0;
    selFound = 1'b0;
    for (int k = NREQ; k >= 1; k--) begin
      int idx;
      idx = (int'(last_q) + k) % NREQ;
      if (arb.req_valid[idx]) begin
        sel      = GW'(idx);
        selFound = 1'b1;
      end
    end
  end

  always_comb begin
    latClamped = arb.cfg_lat;
    if (arb.cfg_lat == '0) begin
      latClamped = LW'(1);
    end else if (int'(arb.cfg_lat) > MAX_LAT) begin
      latClamped = LW'(MAX_LAT);
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    grant_d   = grant_q;
    reqReady  = '0;
    respValid = '0;
    case (state_q)
      IDLE: begin
        if (selFound) begin
          reqReady[sel] = 1'b1;
          grant_d       = sel;
          last_d        = sel;
          cnt_d         = latClamped - LW'(1);
          state_d       = (latClamped == LW'(1)) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - LW'(1);
        if (cnt_q == LW'(1)) begin
          state_d = RESP;
        end
      end
      RESP: begin
        respValid[grant_q] = 1'b1;
        if (arb.resp_ready[grant_q]) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= GW'(NREQ - 1);
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      grant_q <= grant_d;
    end
  end

  // The accept path is combinational, so it must be forced low while reset is held.
  assign arb.req_ready  = rst_n ? reqReady : '0;
  assign arb.resp_valid = respValid;
  assign arb.busy       = (state_q != IDLE);
  assign arb.grant_id   = grant_q;
endmodule
